// File: rtl/ysyx_22040895_ifu_prefetch_pkg.sv
// Shared IFU widths and defaults used by the prefetching fetch unit.
package ysyx_22040895_ifu_prefetch_pkg;

  localparam int unsigned ysyx_22040895_InstBus           = 32;
  localparam int unsigned ysyx_22040895_InstAddrBus       = 64;
  localparam int unsigned ysyx_22040895_IfuDepth          = 4;
  localparam int unsigned ysyx_22040895_IfuMaxOutstanding = 2;
  localparam logic [63:0] ysyx_22040895_ResetPC           = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22040895_fetch_fifo.sv
// Synchronous FIFO of {pc, inst} entries; flush overrides push and pop.
module ysyx_22040895_fetch_fifo
  import ysyx_22040895_ifu_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH = ysyx_22040895_IfuDepth,
  parameter int unsigned WIDTH = ysyx_22040895_InstAddrBus + ysyx_22040895_InstBus
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  // Head reads as zero when empty so idle outputs are deterministic.
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/ysyx_22040895_ifu_prefetch.sv
// Pipelined instruction fetch with prefetch FIFO and redirect flush.
// Optional counters enabled by defining YSYX_22040895_IFU_PERF_EN.
module ysyx_22040895_ifu_prefetch
  import ysyx_22040895_ifu_prefetch_pkg::*;
#(
  parameter int unsigned     XLEN            = ysyx_22040895_InstAddrBus,
  parameter int unsigned     ILEN            = ysyx_22040895_InstBus,
  parameter int unsigned     DEPTH           = ysyx_22040895_IfuDepth,
  parameter int unsigned     MAX_OUTSTANDING = ysyx_22040895_IfuMaxOutstanding,
  parameter logic [XLEN-1:0] RESET_PC        = XLEN'(ysyx_22040895_ResetPC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [XLEN-1:0] mem_req_addr_o,
  input  logic            mem_resp_valid_i,
  input  logic [ILEN-1:0] mem_resp_inst_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [ILEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o,
`ifdef YSYX_22040895_IFU_PERF_EN
  output logic [63:0]     perf_fetched_o,
  output logic [63:0]     perf_discarded_o,
  output logic [63:0]     perf_stall_o,
`endif
  output logic            busy_o
);

  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]      r_req_pc, r_resp_pc, w_req_pc_nxt, w_resp_pc_nxt, w_redirect_pc;
  logic [OW-1:0]        r_outstanding, r_discard, w_outstanding_nxt, w_discard_nxt;
  logic [CW-1:0]        w_count;
  logic [31:0]          w_occupancy;
  logic                 w_issue, w_fire, w_push, w_pop, w_empty, w_full;
  logic [XLEN+ILEN-1:0] w_head;

  assign w_redirect_pc = redirect_pc_i & ~XLEN'(3);
  // Discarded responses never land in the FIFO, so they hold no reservation.
  assign w_occupancy   = 32'(w_count) + 32'(r_outstanding) - 32'(r_discard);
  assign w_issue       = !rst && !redirect_i && !w_full &&
                         (32'(r_outstanding) < MAX_OUTSTANDING) && (w_occupancy < DEPTH);
  assign w_fire        = w_issue && mem_req_ready_i;
  assign w_push        = mem_resp_valid_i && !redirect_i && (r_discard == '0);
  assign w_pop         = !w_empty && inst_ready_i;

  always_comb begin
    w_req_pc_nxt      = r_req_pc;
    w_resp_pc_nxt     = r_resp_pc;
    w_outstanding_nxt = r_outstanding + OW'(w_fire) - OW'(mem_resp_valid_i);
    w_discard_nxt     = r_discard;
    if (redirect_i) begin
      w_req_pc_nxt  = w_redirect_pc;
      w_resp_pc_nxt = w_redirect_pc;
      w_discard_nxt = r_outstanding - OW'(mem_resp_valid_i);
    end else begin
      if (w_fire) w_req_pc_nxt = r_req_pc + XLEN'(4);
      if (w_push) w_resp_pc_nxt = r_resp_pc + XLEN'(4);
      if (mem_resp_valid_i && (r_discard != '0)) w_discard_nxt = r_discard - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_pc      <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      r_req_pc      <= w_req_pc_nxt;
      r_resp_pc     <= w_resp_pc_nxt;
      r_outstanding <= w_outstanding_nxt;
      r_discard     <= w_discard_nxt;
    end
  end

  ysyx_22040895_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN + ILEN)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect_i),
    .i_data  ({r_resp_pc, mem_resp_inst_i}),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign mem_req_valid_o = w_issue;
  assign mem_req_addr_o  = r_req_pc;
  assign inst_valid_o    = !w_empty;
  assign inst_o          = w_head[ILEN-1:0];
  assign pc_o            = w_head[XLEN+ILEN-1:ILEN];
  assign busy_o          = (r_outstanding != '0) || (r_discard != '0);

`ifdef YSYX_22040895_IFU_PERF_EN
  logic [63:0] r_perf_fetched, r_perf_discarded, r_perf_stall;
  logic        w_drop;

  assign w_drop = mem_resp_valid_i && !w_push;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched   <= '0;
      r_perf_discarded <= '0;
      r_perf_stall     <= '0;
    end else begin
      if (w_push && (r_perf_fetched != '1)) r_perf_fetched <= r_perf_fetched + 64'd1;
      if (w_drop && (r_perf_discarded != '1)) r_perf_discarded <= r_perf_discarded + 64'd1;
      if (inst_ready_i && w_empty && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 64'd1;
    end
  end

  assign perf_fetched_o   = r_perf_fetched;
  assign perf_discarded_o = r_perf_discarded;
  assign perf_stall_o     = r_perf_stall;
`endif

endmodule

// File: tb/tb_ysyx_22040895_ifu_prefetch.sv
// Scoreboard bench for the prefetching IFU with a fixed-latency memory model.
module tb_ysyx_22040895_ifu_prefetch;

  localparam int unsigned MAX = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [63:0] mem_req_addr_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_inst_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        inst_valid_o, inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] pc_o;
  logic        busy_o;
`ifdef YSYX_22040895_IFU_PERF_EN
  logic [63:0] perf_fetched_o, perf_discarded_o, perf_stall_o;
`endif

  ysyx_22040895_ifu_prefetch dut (
    .clk              (clk),
    .rst              (rst),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_inst_i  (mem_resp_inst_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
`ifdef YSYX_22040895_IFU_PERF_EN
    .perf_fetched_o   (perf_fetched_o),
    .perf_discarded_o (perf_discarded_o),
    .perf_stall_o     (perf_stall_o),
`endif
    .busy_o           (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    int unsigned epoch;
    logic [31:0] inst;
  } mem_ent_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  mem_ent_t    mem_q[$];
  exp_t        exp_q[$];
  int unsigned n_checks = 0, n_errors = 0;
  int unsigned cyc = 0, lat = 1, epoch = 0, phase_reqs = 0, max_seen = 0;
  int unsigned fetched = 0, discarded = 0, stalls = 0;
  int          first_req_cyc = -1, first_val_cyc = -1;
  logic [63:0] first_val_pc, exp_addr;
  logic        req_ready = 1'b0, idu_ready = 1'b0, redir_now = 1'b0, arm_e = 1'b0, e_hit = 1'b0;
  logic [63:0] redir_pc = '0;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, observe 1ns later, commit at posedge.
  task automatic tick();
    int unsigned inflight;
    logic        have_resp;
    int unsigned resp_epoch;
    exp_t        e;
    @(negedge clk);
    inflight         = mem_q.size();
    have_resp        = 1'b0;
    resp_epoch       = 0;
    mem_resp_valid_i = 1'b0;
    mem_resp_inst_i  = '0;
    if (mem_q.size() != 0 && mem_q[0].due == cyc) begin
      have_resp        = 1'b1;
      mem_resp_valid_i = 1'b1;
      mem_resp_inst_i  = mem_q[0].inst;
      resp_epoch       = mem_q[0].epoch;
      void'(mem_q.pop_front());
    end
    mem_req_ready_i = req_ready;
    inst_ready_i    = idu_ready;
    redirect_i      = redir_now;
    redirect_pc_i   = redir_pc;
    #1;
    if (arm_e && have_resp && inflight == MAX && inst_valid_o) begin
      redirect_i    = 1'b1;
      redirect_pc_i = 64'h9000_0010;
      inst_ready_i  = 1'b1;
      arm_e         = 1'b0;
      e_hit         = 1'b1;
      #1;
    end
    if (inflight > max_seen) max_seen = inflight;
    if (inflight == MAX) check("req_hold_at_max", 64'(mem_req_valid_o), 64'd0);
    if (redirect_i) check("no_req_on_redirect", 64'(mem_req_valid_o), 64'd0);
    if (inst_valid_o && inst_ready_i) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", 64'(inst_valid_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pc_o", pc_o, e.pc);
        check("inst_o", 64'(inst_o), 64'(e.inst));
      end
    end
    if (inst_valid_o && first_val_cyc < 0) begin
      first_val_cyc = int'(cyc);
      first_val_pc  = pc_o;
    end
    if (have_resp) begin
      if (resp_epoch == epoch && !redirect_i) fetched++;
      else discarded++;
    end
    if (inst_ready_i && !inst_valid_o) stalls++;
    if (redirect_i) begin
      exp_q.delete();
      epoch++;
      exp_addr = {redirect_pc_i[63:2], 2'b00};
    end else if (mem_req_valid_o && mem_req_ready_i) begin
      check("req_addr", mem_req_addr_o, exp_addr);
      mem_q.push_back('{due: cyc + lat, epoch: epoch, inst: inst_of(mem_req_addr_o)});
      exp_q.push_back('{pc: exp_addr, inst: inst_of(exp_addr)});
      exp_addr += 64'd4;
      phase_reqs++;
      if (first_req_cyc < 0) first_req_cyc = int'(cyc);
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    bit done;
    done      = 1'b0;
    req_ready = 1'b0;
    idu_ready = 1'b1;
    redir_now = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      #1;
      done = !busy_o && !inst_valid_o && (mem_q.size() == 0);
    end
    check("drained", {62'd0, busy_o, inst_valid_o}, 64'd0);
    check("scoreboard_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst              = 1'b1;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_inst_i  = '0;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    inst_ready_i     = 1'b0;
    exp_addr         = 64'h8000_0000;
    #13;
    check("rst_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("rst_req_addr", mem_req_addr_o, 64'h8000_0000);
    check("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    check("rst_inst", 64'(inst_o), 64'd0);
    check("rst_pc", pc_o, 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    // Streaming with 1-cycle memory.
    lat = 1; req_ready = 1'b1; idu_ready = 1'b1;
    run(12);
    check("first_valid_latency", 64'(first_val_cyc - first_req_cyc), 64'd2);
    check("first_pc", first_val_pc, 64'h8000_0000);
    drain();

    // Decode stalled: four reservations, then issue stops.
    phase_reqs = 0; req_ready = 1'b1; idu_ready = 1'b0;
    run(8);
    #1;
    check("stall_req_count", 64'(phase_reqs), 64'd4);
    check("stall_req_valid", 64'(mem_req_valid_o), 64'd0);
    check("stall_inst_valid", 64'(inst_valid_o), 64'd1);
    idu_ready = 1'b1;
    run(12);
    drain();

    // Slow memory: outstanding capped.
    lat = 3; max_seen = 0; req_ready = 1'b1;
    run(20);
    check("max_inflight", 64'(max_seen), 64'(MAX));
    drain();

    // Redirect with two requests in flight.
    lat = 3; req_ready = 1'b1;
    run(2);
    redir_now = 1'b1; redir_pc = 64'h8000_1002;
    tick();
    redir_now = 1'b0;
    #1;
    check("redir_busy", 64'(busy_o), 64'd1);
    check("redir_flushed", 64'(inst_valid_o), 64'd0);
    first_val_cyc = -1;
    run(15);
    check("redir_first_pc", first_val_pc, 64'h8000_1000);
    drain();
`ifdef YSYX_22040895_IFU_PERF_EN
    #1;
    check("perf_discarded", perf_discarded_o, 64'd2);
    check("perf_fetched", perf_fetched_o, 64'(fetched));
    check("perf_stall", perf_stall_o, 64'(stalls));
`endif

    // Redirect coinciding with a response and a decode handshake.
    lat = 2; req_ready = 1'b1; idu_ready = 1'b0; arm_e = 1'b1; e_hit = 1'b0;
    for (int i = 0; i < 20 && !e_hit; i++) tick();
    #1;
    check("e_redirect_hit", 64'(e_hit), 64'd1);
    check("e_busy_discard", 64'(busy_o), 64'd1);
    check("e_fifo_empty", 64'(inst_valid_o), 64'd0);
    arm_e = 1'b0; idu_ready = 1'b1;
    run(10);
    drain();
`ifdef YSYX_22040895_IFU_PERF_EN
    #1;
    check("perf_discarded_end", perf_discarded_o, 64'(discarded));
    check("perf_fetched_end", perf_fetched_o, 64'(fetched));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_ifu_prefetch.md
Name: ysyx_22040895_ifu_prefetch

Overview:
Parametrised next-generation instruction fetch unit. It replaces the single-cycle, combinational instruction-ROM fetch with a pipelined request/response memory interface. It supports up to MAX_OUTSTANDING in-flight requests, a DEPTH-entry prefetch FIFO, and a valid/ready handshake to decode. It sits between the instruction memory port and the IDU; the EXU/CU jump_branch result drives the redirect inputs.

Parameters:
XLEN, 64, PC/address width
ILEN, 32, instruction width
DEPTH, 4, prefetch FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max issued-but-unreturned memory requests (>=1)
RESET_PC, 64'h8000_0000, first fetch address after reset

Ports:
clk  in  1  clock; all state on posedge
rst  in  1  asynchronous, active-high reset
mem_req_valid_o  out  1  fetch request valid
mem_req_ready_i  in  1  memory accepts request this cycle
mem_req_addr_o  out  XLEN  fetch address, 4-byte aligned
mem_resp_valid_i  in  1  in-order response valid; always accepted
mem_resp_inst_i  in  ILEN  response instruction
redirect_i  in  1  jump/branch taken; flush and refetch
redirect_pc_i  in  XLEN  new PC
inst_valid_o  out  1  FIFO head valid to IDU
inst_ready_i  in  1  IDU accepts head
inst_o  out  ILEN  head instruction
pc_o  out  XLEN  PC of head instruction
busy_o  out  1  outstanding requests or discards pending

Behaviour:
- Reset (async): req_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, discard=0, FIFO empty. Outputs: mem_req_valid_o=0, mem_req_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, pc_o=0, busy_o=0. Reset mid-transaction drops all in-flight state. Responses already in flight are the memory model's responsibility.
- Issue: mem_req_valid_o = !redirect_i && outstanding<MAX_OUTSTANDING && (fifo_count + outstanding - discard) < DEPTH. mem_req_addr_o = req_pc. On valid&&ready: req_pc += 4 (mod 2^XLEN), outstanding += 1.
- FIFO space is reserved at issue time, so a push can never overflow.
- Response: mem_resp_valid_i decrements outstanding.
  - If discard>0: drop the response and decrement discard.
  - Otherwise: push {resp_pc, inst} and set resp_pc += 4.
- Issue and response in the same cycle give a net outstanding change of 0.
- Output: the FIFO head is registered; inst_valid_o=(count!=0). A pushed entry is visible the cycle after the response cycle, so min latency is request -> response +1 -> inst_valid_o +1. Pop occurs on inst_valid_o&&inst_ready_i. Push and pop in the same cycle keep count unchanged, including when full.
- Redirect (highest priority), all in the same cycle:
  - FIFO cleared; a decode handshake completing that cycle still counts as delivered.
  - req_pc and resp_pc load {redirect_pc_i[XLEN-1:2],2'b00}.
  - No request is issued.
  - discard <= outstanding - (mem_resp_valid_i ? 1 : 0). A response arriving that cycle is dropped.
  - The first new request is issued the next cycle.
- Back-to-back redirects: each one reloads the PCs and recomputes discard. Responses are never pushed while discard>0.
- busy_o = (outstanding!=0)||(discard!=0).
- Wrap-around: req_pc and resp_pc wrap mod 2^XLEN. FIFO pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.

Optional Feature:
YSYX_22040895_IFU_PERF_EN:
- When defined, adds three 64-bit counters plus output ports perf_fetched_o, perf_discarded_o and perf_stall_o:
  - pushed instructions;
  - discarded responses;
  - cycles with inst_ready_i && !inst_valid_o.
- Counters reset to 0 with rst and saturate at all-ones.
- When undefined, the counters and ports are absent and behaviour is otherwise identical.

Decomposition:
- Shared define file gains: ysyx_22040895_IfuDepth, ysyx_22040895_IfuMaxOutstanding, ysyx_22040895_ResetPC.
- Existing ysyx_22040895_InstBus and ysyx_22040895_InstAddrBus are reused for widths.
- One sub-module: ysyx_22040895_fetch_fifo. It is a synchronous FIFO of {pc,inst} with push, pop, flush, count and empty/full signals, and flush has priority over push.

Test Plan:
- Reset, mem ready always, 1-cycle response, inst_ready_i=1 -> addresses 0x80000000, 0x80000004, ... issued; the first inst_valid_o appears 2 cycles after the first request with pc_o=0x80000000.
- inst_ready_i=0, memory ready -> 4 requests issued, then mem_req_valid_o=0; FIFO count=4 and holds; raising ready resumes issue one request per pop.
- Response latency 3 cycles, MAX_OUTSTANDING=2 -> never more than 2 requests in flight; mem_req_valid_o deasserts while outstanding=2.
- 2 requests in flight, redirect_i with redirect_pc_i=0x80001002 -> FIFO flushed, both responses dropped, next request address 0x80001000, first pc_o=0x80001000.
- Redirect in the same cycle as a response and an IDU handshake -> response dropped, discard=outstanding-1, handshake counted, FIFO empty next cycle.
- With YSYX_22040895_IFU_PERF_EN, run the redirect test -> perf_discarded_o=2 and perf_fetched_o equals the number of pushed instructions.
